// File: rtl/gt_pkg.sv
// Shared types and constants for the GT receive capture path.
// Covers the capture FSM states, the completion status codes and the default alignment marker.
package gt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    localparam logic [1:0] CAP_OK       = 2'd0;
    localparam logic [1:0] CAP_TIMEOUT  = 2'd1;
    localparam logic [1:0] CAP_LINKLOST = 2'd2;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hBCBC_50C5;

endpackage

// File: rtl/gt_rx_lane_buf.sv
// Per-lane capture buffer: simple dual-port RAM with a registered read port.
// Only the read register is reset; the stored words survive a reset.
module gt_rx_lane_buf
    import gt_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_d;
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gt_rx_capture.sv
// GT receive capture: arms on software start, aligns to a sync word on the master lane,
// then stores cap_len all-valid beats per lane into per-lane buffers for readback.
module gt_rx_capture
    import gt_pkg::*;
#(
    parameter int                         GT_CHN_NUM      = 6,
    parameter int                         USER_DATA_WIDTH = 32,
    parameter int                         RAM_DEPTH       = 1024,
    parameter int                         MASTER_CHN      = 3,
    parameter logic [USER_DATA_WIDTH-1:0] SYNC_WORD       = SYNC_WORD_DEFAULT,
    parameter int                         ARM_TIMEOUT     = 2**20
) (
    input  logic                                  gt_clk,
    input  logic                                  gt_reset,
    input  logic [GT_CHN_NUM*USER_DATA_WIDTH-1:0] rx_data,
    input  logic [GT_CHN_NUM-1:0]                 rx_valid,
    input  logic                                  rx_resetdone,
    input  logic                                  cap_start,
    input  logic                                  cap_reset,
    input  logic [$clog2(RAM_DEPTH):0]            cap_len,
    input  logic [$clog2(GT_CHN_NUM)-1:0]         rd_chn,
    input  logic [$clog2(RAM_DEPTH)-1:0]          rd_addr,
    output logic [USER_DATA_WIDTH-1:0]            rd_data,
    output logic                                  cap_busy,
    output logic                                  cap_done,
    output logic [$clog2(RAM_DEPTH):0]            cap_words,
    output logic [GT_CHN_NUM-1:0]                 lane_gap,
    output logic [1:0]                            cap_status
);

    localparam int W   = USER_DATA_WIDTH;
    localparam int AW  = $clog2(RAM_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CHW = $clog2(GT_CHN_NUM);
    localparam int ACW = $clog2(ARM_TIMEOUT + 1);
    localparam logic [LW-1:0]  DEPTH_L  = LW'(RAM_DEPTH);
    localparam logic [ACW-1:0] ARM_LAST = ACW'(ARM_TIMEOUT - 1);

    cap_state_e             state_q, state_d;
    logic [LW-1:0]          eff_len_q, eff_len_d;
    logic [LW-1:0]          cap_words_q, cap_words_d;
    logic [GT_CHN_NUM-1:0]  lane_gap_q, lane_gap_d;
    logic [1:0]             cap_status_q, cap_status_d;
    logic [ACW-1:0]         arm_cnt_q, arm_cnt_d;
    logic [CHW-1:0]         rd_sel_q, rd_sel_d;
    logic                   wr_en;
    logic [LW-1:0]          req_len;
    logic                   sync_hit;
    logic [W-1:0]           lane_rd [GT_CHN_NUM];
    logic [W-1:0]           rd_mux;

    assign req_len  = (cap_len == '0 || cap_len > DEPTH_L) ? DEPTH_L : cap_len;
    assign sync_hit = rx_valid[MASTER_CHN] && (rx_data[MASTER_CHN*W +: W] == SYNC_WORD);

    // Soft reset outranks everything; link loss outranks alignment, timeout and data.
    always_comb begin
        state_d      = state_q;
        eff_len_d    = eff_len_q;
        cap_words_d  = cap_words_q;
        lane_gap_d   = lane_gap_q;
        cap_status_d = cap_status_q;
        arm_cnt_d    = arm_cnt_q;
        rd_sel_d     = rd_chn;
        wr_en        = 1'b0;

        if (cap_reset) begin
            state_d      = IDLE;
            cap_words_d  = '0;
            lane_gap_d   = '0;
            cap_status_d = CAP_OK;
            arm_cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (cap_start && rx_resetdone) begin
                        state_d      = ARMED;
                        eff_len_d    = req_len;
                        cap_words_d  = '0;
                        lane_gap_d   = '0;
                        cap_status_d = CAP_OK;
                        arm_cnt_d    = '0;
                    end
                end
                ARMED: begin
                    if (!rx_resetdone) begin
                        state_d      = DONE;
                        cap_status_d = CAP_LINKLOST;
                    end else if (sync_hit) begin
                        state_d = CAPTURE;
                    end else if (arm_cnt_q == ARM_LAST) begin
                        state_d      = DONE;
                        cap_status_d = CAP_TIMEOUT;
                    end else begin
                        arm_cnt_d = arm_cnt_q + ACW'(1);
                    end
                end
                CAPTURE: begin
                    if (!rx_resetdone) begin
                        state_d      = DONE;
                        cap_status_d = CAP_LINKLOST;
                    end else if (&rx_valid) begin
                        wr_en       = 1'b1;
                        cap_words_d = cap_words_q + LW'(1);
                        if (cap_words_d == eff_len_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        lane_gap_d = lane_gap_q | ~rx_valid;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge gt_clk or posedge gt_reset) begin
        if (gt_reset) begin
            state_q      <= IDLE;
            eff_len_q    <= '0;
            cap_words_q  <= '0;
            lane_gap_q   <= '0;
            cap_status_q <= CAP_OK;
            arm_cnt_q    <= '0;
            rd_sel_q     <= '0;
        end else begin
            state_q      <= state_d;
            eff_len_q    <= eff_len_d;
            cap_words_q  <= cap_words_d;
            lane_gap_q   <= lane_gap_d;
            cap_status_q <= cap_status_d;
            arm_cnt_q    <= arm_cnt_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

    // The write address is the count of words already stored, so it never wraps.
    for (genvar i = 0; i < GT_CHN_NUM; i++) begin : g_lane
        gt_rx_lane_buf #(
            .W     (W),
            .DEPTH (RAM_DEPTH)
        ) u_buf (
            .clk     (gt_clk),
            .rst     (gt_reset),
            .wr_en   (wr_en),
            .wr_addr (cap_words_q[AW-1:0]),
            .wr_data (rx_data[i*W +: W]),
            .rd_addr (rd_addr),
            .rd_data (lane_rd[i])
        );
    end

    // Lane select is registered alongside the RAM read; an unmatched select yields zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < GT_CHN_NUM; i++) begin
            if (rd_sel_q == CHW'(i)) begin
                rd_mux = lane_rd[i];
            end
        end
    end

    assign rd_data    = rd_mux;
    assign cap_busy   = (state_q == ARMED) || (state_q == CAPTURE);
    assign cap_done   = (state_q == DONE);
    assign cap_words  = cap_words_q;
    assign lane_gap   = lane_gap_q;
    assign cap_status = cap_status_q;

endmodule

// File: tb/tb_gt_rx_capture.sv
// Self-checking bench for gt_rx_capture: randomized lane traffic compared every cycle
// against a run-level reference model, plus buffer readback checks.
module tb_gt_rx_capture;

    localparam int N      = 6;
    localparam int W      = 32;
    localparam int DEPTH  = 1024;
    localparam int MASTER = 3;
    localparam int ARM_TO = 100;
    localparam logic [31:0] SYNC = 32'hBCBC_50C5;

    logic           gt_clk;
    logic           gt_reset;
    logic [N*W-1:0] rx_data;
    logic [N-1:0]   rx_valid;
    logic           rx_resetdone;
    logic           cap_start;
    logic           cap_reset;
    logic [10:0]    cap_len;
    logic [2:0]     rd_chn;
    logic [9:0]     rd_addr;
    logic [31:0]    rd_data;
    logic           cap_busy;
    logic           cap_done;
    logic [10:0]    cap_words;
    logic [N-1:0]   lane_gap;
    logic [1:0]     cap_status;

    // Reference model: run phase (0 idle, 1 waiting for marker, 2 storing, 3 finished)
    int          mPhase;
    int          mWords;
    int          mEff;
    int          mArm;
    logic [5:0]  mGap;
    logic [1:0]  mStatus;
    logic [31:0] mMem [N][DEPTH];
    logic [10:0] runLen;

    int vecCount;
    int errCount;

    gt_rx_capture #(
        .GT_CHN_NUM      (N),
        .USER_DATA_WIDTH (W),
        .RAM_DEPTH       (DEPTH),
        .MASTER_CHN      (MASTER),
        .SYNC_WORD       (SYNC),
        .ARM_TIMEOUT     (ARM_TO)
    ) dut (
        .gt_clk       (gt_clk),
        .gt_reset     (gt_reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_resetdone (rx_resetdone),
        .cap_start    (cap_start),
        .cap_reset    (cap_reset),
        .cap_len      (cap_len),
        .rd_chn       (rd_chn),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .cap_busy     (cap_busy),
        .cap_done     (cap_done),
        .cap_words    (cap_words),
        .lane_gap     (lane_gap),
        .cap_status   (cap_status)
    );

    initial gt_clk = 1'b0;
    always #5 gt_clk = ~gt_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("busy",   32'(cap_busy),   32'(mPhase == 1 || mPhase == 2));
        checkOutput("done",   32'(cap_done),   32'(mPhase == 3));
        checkOutput("words",  32'(cap_words),  32'(mWords));
        checkOutput("gap",    32'(lane_gap),   32'(mGap));
        checkOutput("status", 32'(cap_status), 32'(mStatus));
    endtask

    task automatic modelReset();
        mPhase  = 0;
        mWords  = 0;
        mGap    = '0;
        mStatus = 2'd0;
        mArm    = 0;
    endtask

    // Drive one beat, advance the model by one cycle, clock it, then compare.
    task automatic applyStimulus(input logic [5:0] valid, input bit sync, input bit pattern,
                                 input bit start, input bit creset, input bit linkUp);
        logic [31:0] d [N];
        for (int i = 0; i < N; i++) begin
            d[i] = pattern ? ((32'(i) << 24) | 32'(mWords)) : $urandom;
        end
        if (sync) d[MASTER] = SYNC;
        else if (d[MASTER] == SYNC) d[MASTER] = ~SYNC;
        for (int i = 0; i < N; i++) rx_data[i*W +: W] = d[i];
        rx_valid     = valid;
        rx_resetdone = linkUp;
        cap_start    = start;
        cap_reset    = creset;
        cap_len      = runLen;

        if (creset) begin
            modelReset();
        end else if (mPhase == 0 || mPhase == 3) begin
            if (start && linkUp) begin
                modelReset();
                mPhase = 1;
                mEff   = (runLen == 0 || int'(runLen) > DEPTH) ? DEPTH : int'(runLen);
            end
        end else if (!linkUp) begin
            mPhase  = 3;
            mStatus = 2'd2;
        end else if (mPhase == 1) begin
            if (valid[MASTER] && d[MASTER] == SYNC) begin
                mPhase = 2;
            end else begin
                mArm++;
                if (mArm == ARM_TO) begin
                    mPhase  = 3;
                    mStatus = 2'd1;
                end
            end
        end else if (&valid) begin
            for (int i = 0; i < N; i++) mMem[i][mWords] = d[i];
            mWords++;
            if (mWords == mEff) mPhase = 3;
        end else begin
            mGap = mGap | ~valid;
        end

        @(posedge gt_clk);
        #1;
        cap_start = 1'b0;
        cap_reset = 1'b0;
        checkState();
    endtask

    task automatic readCheck(input logic [2:0] chn, input int addr, input logic [31:0] exp, input string tag);
        rd_chn  = chn;
        rd_addr = 10'(addr);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput(tag, rd_data, exp);
    endtask

    function automatic logic [5:0] randValid();
        return ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
    endfunction

    task automatic randomRun(input logic [10:0] len, input int maxBeats);
        int a;
        int ch;
        runLen = len;
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat ($urandom_range(0, 10)) applyStimulus(randValid(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < maxBeats && mPhase == 2; c++) begin
            applyStimulus(randValid(), $urandom_range(0, 7) == 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("runDone", 32'(cap_done), 32'd1);
        repeat (8) begin
            a  = $urandom_range(0, mWords - 1);
            ch = $urandom_range(0, N - 1);
            readCheck(3'(ch), a, mMem[ch][a], "runRd");
        end
    endtask

    initial begin
        vecCount     = 0;
        errCount     = 0;
        gt_reset     = 1'b1;
        rx_data      = '0;
        rx_valid     = '0;
        rx_resetdone = 1'b0;
        cap_start    = 1'b0;
        cap_reset    = 1'b0;
        cap_len      = '0;
        rd_chn       = '0;
        rd_addr      = '0;
        runLen       = '0;
        modelReset();

        #12;
        checkOutput("rstRdData", rd_data,          32'd0);
        checkOutput("rstBusy",   32'(cap_busy),    32'd0);
        checkOutput("rstDone",   32'(cap_done),    32'd0);
        checkOutput("rstWords",  32'(cap_words),   32'd0);
        checkOutput("rstGap",    32'(lane_gap),    32'd0);
        checkOutput("rstStatus", 32'(cap_status),  32'd0);
        @(posedge gt_clk);
        #1;
        gt_reset = 1'b0;
        rx_resetdone = 1'b1;

        $display("[TB] normal run");
        runLen = 11'd16;
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(randValid(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (16) applyStimulus(6'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t1Done",   32'(cap_done),   32'd1);
        checkOutput("t1Words",  32'(cap_words),  32'd16);
        checkOutput("t1Status", 32'(cap_status), 32'd0);
        readCheck(3'd2, 5, 32'h0200_0005, "t1Rd");
        readCheck(3'd5, 15, 32'h0500_000F, "t1RdLast");
        readCheck(3'd6, 5, 32'd0, "t1RdChn6");
        readCheck(3'd7, 5, 32'd0, "t1RdChn7");

        $display("[TB] lane gap run");
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 19; n++) begin
            applyStimulus((n >= 5 && n < 8) ? 6'b111101 : 6'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("t2Gap",   32'(lane_gap),  32'h02);
        checkOutput("t2Words", 32'(cap_words), 32'd16);
        for (int a = 0; a < 16; a++) begin
            readCheck(3'd1, a, 32'h0100_0000 | 32'(a), "t2RdL1");
            readCheck(3'd4, a, 32'h0400_0000 | 32'(a), "t2RdL4");
        end

        $display("[TB] random runs");
        randomRun(11'd1, 50);
        randomRun(11'(($urandom_range(2, 40))), 200);
        randomRun(11'(($urandom_range(2, 40))), 200);

        $display("[TB] arm timeout");
        runLen = 11'd16;
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (ARM_TO + 5) applyStimulus(randValid(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3Status", 32'(cap_status), 32'd1);
        checkOutput("t3Words",  32'(cap_words),  32'd0);

        $display("[TB] link loss");
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (7) applyStimulus(6'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4Status", 32'(cap_status), 32'd2);
        checkOutput("t4Words",  32'(cap_words),  32'd7);
        checkOutput("t4Done",   32'(cap_done),   32'd1);
        repeat (2) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] controls");
        runLen = 11'd20;
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) applyStimulus(6'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5BusyWords", 32'(cap_words), 32'd5);
        applyStimulus(6'h3F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t5RstBusy",  32'(cap_busy),  32'd0);
        checkOutput("t5RstDone",  32'(cap_done),  32'd0);
        checkOutput("t5RstWords", 32'(cap_words), 32'd0);

        runLen = 11'd0;
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 1500 && mPhase == 2; c++) begin
            applyStimulus(randValid(), $urandom_range(0, 15) == 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("t5FullWords", 32'(cap_words), 32'd1024);
        checkOutput("t5FullDone",  32'(cap_done),  32'd1);
        for (int ch = 0; ch < N; ch++) begin
            readCheck(3'(ch), 1023, mMem[ch][1023], "t5RdLast");
        end
        readCheck(3'd0, 0, mMem[0][0], "t5RdFirst");

        $display("[TB] reset mid-capture");
        runLen = 11'd32;
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) applyStimulus(6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        gt_reset = 1'b1;
        #1;
        checkOutput("t6RdData", rd_data,         32'd0);
        checkOutput("t6Busy",   32'(cap_busy),   32'd0);
        checkOutput("t6Done",   32'(cap_done),   32'd0);
        checkOutput("t6Words",  32'(cap_words),  32'd0);
        checkOutput("t6Gap",    32'(lane_gap),   32'd0);
        checkOutput("t6Status", 32'(cap_status), 32'd0);
        modelReset();
        @(posedge gt_clk);
        #1;
        gt_reset = 1'b0;
        readCheck(3'd4, 3, mMem[4][3], "t6Partial");
        randomRun(11'd8, 100);
        checkOutput("t6NewWords", 32'(cap_words), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
